vec_cfg_ctrl: RTL and testbench



---
 rtl/vec_cfg_pkg.sv | 34 +++
 rtl/vec_cfg_ctrl_if.sv | 25 ++
 rtl/vec_cfg_decode.sv | 29 ++
 rtl/vec_cfg_ctrl.sv | 119 +++++++++++
 tb/tb_vec_cfg_ctrl.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/vec_cfg_pkg.sv
// Shared constants, offset-to-index mapping and FSM encoding for the
// exception/interrupt vector configuration block.
package vec_cfg_pkg;

    localparam int NUM_VEC = 20;

    localparam logic [7:0] OFF_SP       = 8'h00;
    localparam logic [7:0] OFF_RESET    = 8'h04;
    localparam logic [7:0] OFF_NMI      = 8'h08;
    localparam logic [7:0] OFF_FAULT    = 8'h0C;
    localparam logic [7:0] OFF_IRQ_BASE = 8'h40;
    localparam logic [7:0] OFF_CTRL     = 8'h80;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_ERR1 = 3'b010,
        ST_ERR2 = 3'b100
    } state_t;

    // Offset within page 0 holds a vector (alignment is checked separately).
    function automatic logic is_vec_offset(input logic [7:0] off);
        return (off inside {OFF_SP, OFF_RESET, OFF_NMI, OFF_FAULT}) ||
               (off >= OFF_IRQ_BASE && off < OFF_CTRL);
    endfunction

    // 0x00..0x0C -> 0..3, 0x40..0x7C -> 4..19.
    function automatic logic [4:0] vec_index(input logic [7:0] off);
        return (off >= OFF_IRQ_BASE) ? 5'd4 + {1'b0, off[5:2]}
                                     : {3'b000, off[3:2]};
    endfunction

endpackage

// File: rtl/vec_cfg_ctrl_if.sv
// AHB-lite transfer signals between the system bus master and the
// vector configuration slave.
interface vec_cfg_ctrl_if;

    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic        hwrite;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    modport master (
        output hsel, haddr, htrans, hsize, hwrite, hwdata,
        input  hrdata, hready, hresp
    );

    modport slave (
        input  hsel, haddr, htrans, hsize, hwrite, hwdata,
        output hrdata, hready, hresp
    );

endinterface

// File: rtl/vec_cfg_decode.sv
// Address-phase decode: maps an AHB address/size onto a vector index or the
// CTRL register and flags every address/size based error.
module vec_cfg_decode
    import vec_cfg_pkg::*;
(
    input  logic [31:0] haddr,
    input  logic [2:0]  hsize,
    output logic [4:0]  idx,
    output logic        is_vec,
    output logic        is_ctrl,
    output logic        dec_err
);

    logic [7:0] off;
    logic       page0;
    logic       aligned;
    logic       unused_hi;

    assign off       = haddr[7:0];
    assign page0     = (haddr[15:8] == 8'h00);
    assign aligned   = (haddr[1:0] == 2'b00);
    assign unused_hi = ^haddr[31:16];

    assign is_vec  = page0 && aligned && is_vec_offset(off);
    assign is_ctrl = page0 && (off == OFF_CTRL);
    assign idx     = is_vec ? vec_index(off) : 5'd0;
    assign dec_err = !(is_vec || is_ctrl) || (hsize != HSIZE_WORD);

endmodule

// File: rtl/vec_cfg_ctrl.sv
// AHB-lite register file for the 20 exception/interrupt vectors with a sticky
// LOCK bit; refused transfers get the two-cycle AHB ERROR response.
module vec_cfg_ctrl
    import vec_cfg_pkg::*;
#(
    parameter logic [31:0] SP_RST  = 32'h2000_1000,
    parameter logic [31:0] VEC_RST = 32'h0000_0000
) (
    input  logic                   hclk,
    input  logic                   hresetn,
    vec_cfg_ctrl_if.slave          ahb,
    output logic [32*NUM_VEC-1:0]  vec_flat,
    output logic                   vec_upd,
    output logic                   lock_o
);

    state_t      state, state_nxt;
    logic [31:0] vec_q [NUM_VEC];
    logic        lock;
    logic        wr_pend;
    logic        wr_ctrl;
    logic [4:0]  wr_idx;

    logic [4:0]  idx;
    logic        is_vec, is_ctrl, dec_err;
    logic        accept, eff_lock, xfer_err, xfer_ok, commit_vec;
    logic [31:0] rd_data;
    logic        unused_trans;

    vec_cfg_decode u_decode (
        .haddr   (ahb.haddr),
        .hsize   (ahb.hsize),
        .idx     (idx),
        .is_vec  (is_vec),
        .is_ctrl (is_ctrl),
        .dec_err (dec_err)
    );

    assign unused_trans = ahb.htrans[0];

    // hready is low only in ERR1, so the address phase is sampled in every other state.
    assign accept     = ahb.hsel && ahb.htrans[1] && (state != ST_ERR1);
    assign eff_lock   = lock || (wr_pend && wr_ctrl && ahb.hwdata[0]);
    assign xfer_err   = dec_err || (ahb.hwrite && is_vec && eff_lock);
    assign xfer_ok    = accept && !xfer_err;
    assign commit_vec = wr_pend && !wr_ctrl;

    // Read mux with forwarding of the write currently in its data phase.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        rd_data = '0;
        if (is_ctrl) begin
            rd_data = {31'b0, eff_lock};
        end else if (is_vec) begin
            rd_data = (commit_vec && wr_idx == idx) ? ahb.hwdata : vec_q[idx];
        end
    end

    always_comb begin
        state_nxt  = state;
        ahb.hready = 1'b1;
        ahb.hresp  = 1'b0;
        unique case (state)
            ST_IDLE: if (accept && xfer_err) state_nxt = ST_ERR1;
            ST_ERR1: begin
                ahb.hready = 1'b0;
                ahb.hresp  = 1'b1;
                state_nxt  = ST_ERR2;
            end
            ST_ERR2: begin
                ahb.hresp = 1'b1;
                state_nxt = (accept && xfer_err) ? ST_ERR1 : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: all clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            wr_pend    <= 1'b0;
            wr_ctrl    <= 1'b0;
            wr_idx     <= '0;
            lock       <= 1'b0;
            vec_upd    <= 1'b0;
            ahb.hrdata <= '0;
        end else begin
            wr_pend    <= xfer_ok && ahb.hwrite;
            vec_upd    <= commit_vec;
            ahb.hrdata <= (xfer_ok && !ahb.hwrite) ? rd_data : '0;
            if (xfer_ok) begin
                wr_ctrl <= is_ctrl;
                wr_idx  <= idx;
            end
            if (wr_pend && wr_ctrl && ahb.hwdata[0]) lock <= 1'b1;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            // NOTE: storage is flops, not RAM, so each entry is reset to its architectural value.
            for (int i = 0; i < NUM_VEC; i++) vec_q[i] <= (i == 0) ? SP_RST : VEC_RST;
        end else if (commit_vec) begin
            vec_q[wr_idx] <= ahb.hwdata;
        end
    end

    for (genvar g = 0; g < NUM_VEC; g++) begin : g_flat
        assign vec_flat[32*g +: 32] = vec_q[g];
    end

    assign lock_o = lock;

endmodule

// File: tb/tb_vec_cfg_ctrl.sv
// Directed bench for vec_cfg_ctrl: reset values, forwarding, lock, ERROR
// sequencing and reset during a pending write.
module tb_vec_cfg_ctrl;
    import vec_cfg_pkg::*;

    logic         hclk = 1'b0;
    logic         hresetn;
    logic [639:0] vec_flat;
    logic         vec_upd;
    logic         lock_o;
    int           checks = 0;
    int           errors = 0;

    vec_cfg_ctrl_if bus ();

    vec_cfg_ctrl #(
        .SP_RST  (32'h2000_1000),
        .VEC_RST (32'h0000_0000)
    ) dut (
        .hclk     (hclk),
        .hresetn  (hresetn),
        .ahb      (bus.slave),
        .vec_flat (vec_flat),
        .vec_upd  (vec_upd),
        .lock_o   (lock_o)
    );

    always #5 hclk = ~hclk;

    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic addr_ph(input logic [31:0] a, input logic w, input logic [2:0] sz);
        bus.hsel   = 1'b1;
        bus.htrans = 2'b10;
        bus.haddr  = a;
        bus.hwrite = w;
        bus.hsize  = sz;
    endtask

    task automatic idle_bus();
        bus.hsel   = 1'b0;
        bus.htrans = 2'b00;
        bus.hwrite = 1'b0;
        bus.haddr  = '0;
        bus.hsize  = 3'b010;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        hresetn    = 1'b0;
        bus.hwdata = '0;
        idle_bus();
        step();
        step();
        check("rst_hrdata", bus.hrdata, 32'h0);
        check("rst_hready", {31'b0, bus.hready}, 32'h1);
        check("rst_hresp", {31'b0, bus.hresp}, 32'h0);
        check("rst_vec_upd", {31'b0, vec_upd}, 32'h0);
        check("rst_lock", {31'b0, lock_o}, 32'h0);
        check("rst_vec0", vec_flat[31:0], 32'h2000_1000);
        check("rst_vec1", vec_flat[63:32], 32'h0);
        hresetn = 1'b1;
        step();

        // Reset-value reads
        addr_ph(32'h00, 1'b0, 3'b010);
        step();
        check("rd_sp", bus.hrdata, 32'h2000_1000);
        check("rd_sp_hready", {31'b0, bus.hready}, 32'h1);
        check("rd_sp_hresp", {31'b0, bus.hresp}, 32'h0);
        addr_ph(32'h04, 1'b0, 3'b010);
        step();
        check("rd_reset", bus.hrdata, 32'h0);
        idle_bus();
        step();
        check("idle_hrdata", bus.hrdata, 32'h0);

        // Unmapped read before lock, then CTRL read issued in ERR2
        addr_ph(32'h20, 1'b0, 3'b010);
        step();
        check("e20_err1_hready", {31'b0, bus.hready}, 32'h0);
        check("e20_err1_hresp", {31'b0, bus.hresp}, 32'h1);
        check("e20_hrdata", bus.hrdata, 32'h0);
        idle_bus();
        step();
        check("e20_err2_hready", {31'b0, bus.hready}, 32'h1);
        check("e20_err2_hresp", {31'b0, bus.hresp}, 32'h1);
        addr_ph(32'h80, 1'b0, 3'b010);
        step();
        check("ctrl_rd0_hresp", {31'b0, bus.hresp}, 32'h0);
        check("ctrl_rd0_hready", {31'b0, bus.hready}, 32'h1);
        check("ctrl_rd0", bus.hrdata, 32'h0);
        idle_bus();
        step();

        // Write 0x44 then back-to-back read (forwarding)
        addr_ph(32'h44, 1'b1, 3'b010);
        step();
        bus.hwdata = 32'hDEAD_BEEF;
        addr_ph(32'h44, 1'b0, 3'b010);
        step();
        check("fwd_hrdata", bus.hrdata, 32'hDEAD_BEEF);
        check("fwd_vec5", vec_flat[191:160], 32'hDEAD_BEEF);
        check("fwd_vec_upd_hi", {31'b0, vec_upd}, 32'h1);
        idle_bus();
        step();
        check("fwd_vec_upd_lo", {31'b0, vec_upd}, 32'h0);

        // Back-to-back writes 0x00 and 0x0C
        addr_ph(32'h00, 1'b1, 3'b010);
        step();
        bus.hwdata = 32'h1111_2222;
        addr_ph(32'h0C, 1'b1, 3'b010);
        step();
        check("ww_vec0", vec_flat[31:0], 32'h1111_2222);
        check("ww_upd1", {31'b0, vec_upd}, 32'h1);
        check("ww_hready", {31'b0, bus.hready}, 32'h1);
        bus.hwdata = 32'h3333_4444;
        idle_bus();
        step();
        check("ww_vec3", vec_flat[127:96], 32'h3333_4444);
        check("ww_upd2", {31'b0, vec_upd}, 32'h1);
        step();
        check("ww_upd_lo", {31'b0, vec_upd}, 32'h0);

        // Lock, then a vector write in the very next address phase
        addr_ph(32'h80, 1'b1, 3'b010);
        step();
        bus.hwdata = 32'h0000_0001;
        addr_ph(32'h08, 1'b1, 3'b010);
        step();
        check("lk_lock", {31'b0, lock_o}, 32'h1);
        check("lk_err1_hready", {31'b0, bus.hready}, 32'h0);
        check("lk_err1_hresp", {31'b0, bus.hresp}, 32'h1);
        check("lk_upd_a", {31'b0, vec_upd}, 32'h0);
        bus.hwdata = 32'h0000_1234;
        idle_bus();
        step();
        check("lk_err2_hready", {31'b0, bus.hready}, 32'h1);
        check("lk_err2_hresp", {31'b0, bus.hresp}, 32'h1);
        check("lk_upd_b", {31'b0, vec_upd}, 32'h0);
        step();
        check("lk_idle_hresp", {31'b0, bus.hresp}, 32'h0);
        check("lk_vec2", vec_flat[95:64], 32'h0);
        check("lk_upd_c", {31'b0, vec_upd}, 32'h0);

        // Error 0x0104, then a size error issued in ERR2, then CTRL read
        addr_ph(32'h0104, 1'b0, 3'b010);
        step();
        check("e104_err1_hready", {31'b0, bus.hready}, 32'h0);
        check("e104_err1_hresp", {31'b0, bus.hresp}, 32'h1);
        check("e104_hrdata", bus.hrdata, 32'h0);
        idle_bus();
        step();
        check("e104_err2_hready", {31'b0, bus.hready}, 32'h1);
        check("e104_err2_hresp", {31'b0, bus.hresp}, 32'h1);
        addr_ph(32'h04, 1'b0, 3'b001);
        step();
        check("esz_err1_hready", {31'b0, bus.hready}, 32'h0);
        check("esz_err1_hresp", {31'b0, bus.hresp}, 32'h1);
        check("esz_hrdata", bus.hrdata, 32'h0);
        idle_bus();
        step();
        check("esz_err2_hready", {31'b0, bus.hready}, 32'h1);
        check("esz_err2_hresp", {31'b0, bus.hresp}, 32'h1);
        step();
        check("esz_idle_hresp", {31'b0, bus.hresp}, 32'h0);
        check("esz_idle_hready", {31'b0, bus.hready}, 32'h1);
        addr_ph(32'h80, 1'b0, 3'b010);
        step();
        check("ctrl_rd1", bus.hrdata, 32'h1);
        check("ctrl_rd1_hresp", {31'b0, bus.hresp}, 32'h0);
        idle_bus();
        step();

        // Reset during the data phase of a write to 0x7C
        addr_ph(32'h7C, 1'b1, 3'b010);
        step();
        bus.hwdata = 32'hCAFE_0001;
        idle_bus();
        hresetn = 1'b0;
        step();
        hresetn = 1'b1;
        step();
        check("rm_vec19", vec_flat[639:608], 32'h0);
        check("rm_vec5", vec_flat[191:160], 32'h0);
        check("rm_vec0", vec_flat[31:0], 32'h2000_1000);
        check("rm_lock", {31'b0, lock_o}, 32'h0);
        check("rm_vec_upd", {31'b0, vec_upd}, 32'h0);
        addr_ph(32'h7C, 1'b0, 3'b010);
        step();
        check("rm_rd7c", bus.hrdata, 32'h0);

        // CTRL write followed by back-to-back CTRL read
        addr_ph(32'h80, 1'b1, 3'b010);
        step();
        bus.hwdata = 32'h0000_0001;
        addr_ph(32'h80, 1'b0, 3'b010);
        step();
        check("ctrl_fwd", bus.hrdata, 32'h1);
        check("ctrl_fwd_lock", {31'b0, lock_o}, 32'h1);
        check("ctrl_fwd_upd", {31'b0, vec_upd}, 32'h0);
        idle_bus();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
